wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the ALU-result and memory-load writeback paths.

---
 rtl/wb_port_arbiter_pkg.sv | 22 ++
 rtl/wb_slot.sv | 39 +++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the writeback port arbiter.
// Holds the register-zero address, mux select encodings and default widths.
package wb_port_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic       SEL_ALU  = 1'b0;
    localparam logic       SEL_MEM  = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a pending register-file write.
// The slot can refill on the same edge it is freed by a grant.
module wb_slot
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic              free,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] waddr,
    output logic              capture
);

    assign ready   = ~full | free;
    assign capture = in_valid & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            data  <= '0;
            waddr <= '0;
        end else if (capture) begin
            full  <= 1'b1;
            data  <= in_data;
            waddr <= in_waddr;
        end else if (free) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback.
// Optional performance counters are built when WB_PERF_EN is defined.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic              rf_hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_to_reg
`ifdef WB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       hold_cnt
`endif
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic              alu_full, mem_full;
    logic              alu_capture, mem_capture;
    logic [DATA_W-1:0] alu_q_data, mem_q_data;
    logic [ADDR_W-1:0] alu_q_waddr, mem_q_waddr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_waddr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_older;
    logic              grant_alu, grant_mem;
    grant_e            grant;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) alu_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (alu_valid),
        .ready    (alu_ready),
        .in_data  (alu_data),
        .in_waddr (alu_waddr),
        .free     (grant_alu),
        .full     (alu_full),
        .data     (alu_q_data),
        .waddr    (alu_q_waddr),
        .capture  (alu_capture)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (mem_valid),
        .ready    (mem_ready),
        .in_data  (mem_data),
        .in_waddr (mem_waddr),
        .free     (grant_mem),
        .full     (mem_full),
        .data     (mem_q_data),
        .waddr    (mem_q_waddr),
        .capture  (mem_capture)
    );

    // Same destination must retire in program order; otherwise MEM wins unless ALU has waited too long.
    always_comb begin
        grant = GNT_NONE;
        if (!rf_hold) begin
            if (alu_full && mem_full) begin
                if (alu_q_waddr == mem_q_waddr)
                    grant = mem_older ? GNT_MEM : GNT_ALU;
                else if (wait_cnt == WAIT_LIMIT)
                    grant = GNT_ALU;
                else
                    grant = GNT_MEM;
            end else if (alu_full) begin
                grant = GNT_ALU;
            end else if (mem_full) begin
                grant = GNT_MEM;
            end
        end
    end

    assign grant_alu = (grant == GNT_ALU);
    assign grant_mem = (grant == GNT_MEM);
    assign sel_data  = grant_mem ? mem_q_data  : alu_q_data;
    assign sel_waddr = grant_mem ? mem_q_waddr : alu_q_waddr;

    // Writes to register zero free the slot but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            mem_to_reg <= SEL_ALU;
        end else begin
            rf_we <= 1'b0;
            if (grant != GNT_NONE && sel_waddr != ADDR_W'(REG_ZERO)) begin
                rf_we      <= 1'b1;
                rf_waddr   <= sel_waddr;
                rf_wdata   <= sel_data;
                mem_to_reg <= grant_mem ? SEL_MEM : SEL_ALU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (!alu_full || grant_alu)
            wait_cnt <= '0;
        else if (grant_mem && wait_cnt != WAIT_LIMIT)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // A newly captured entry is younger than whatever the other slot still holds.
    always_ff @(posedge clk) begin
        if (reset)
            mem_older <= 1'b0;
        else if (alu_capture && mem_capture)
            mem_older <= 1'b1;
        else if (mem_capture)
            mem_older <= 1'b0;
        else if (alu_capture)
            mem_older <= 1'b1;
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
            hold_cnt     <= '0;
        end else begin
            if (alu_full && mem_full && !rf_hold)
                conflict_cnt <= sat_inc16(conflict_cnt);
            if (rf_hold && (alu_full || mem_full))
                hold_cnt <= sat_inc16(hold_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios then randomized traffic
// against an order-tracking reference model; counters checked when WB_PERF_EN is defined.
module tb_wb_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, mem_valid, rf_hold;
    logic              alu_ready, mem_ready;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic [ADDR_W-1:0] alu_waddr, mem_waddr;
    logic              rf_we, mem_to_reg;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
`ifdef WB_PERF_EN
    logic [15:0]       conflict_cnt, hold_cnt;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_data     (alu_data),
        .alu_waddr    (alu_waddr),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .mem_waddr    (mem_waddr),
        .rf_hold      (rf_hold),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .mem_to_reg   (mem_to_reg)
`ifdef WB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .hold_cnt     (hold_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pending entries stamped with arrival order.
    bit          a_full, m_full;
    logic [31:0] a_data, m_data;
    logic [4:0]  a_addr, m_addr;
    int          a_seq, m_seq, seq_ctr, losses;
    logic        exp_we, exp_m2r;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    bit          m2r_known;
    int          exp_conf, exp_hold;
    logic        obs_ar, obs_mr;
    logic [31:0] regfile [32];
    logic        grant_log [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        a_full = 0; m_full = 0;
        a_data = '0; m_data = '0; a_addr = '0; m_addr = '0;
        a_seq = 0; m_seq = 0; seq_ctr = 0; losses = 0;
        exp_we = 0; exp_m2r = 0; exp_waddr = '0; exp_wdata = '0;
        m2r_known = 1; exp_conf = 0; exp_hold = 0;
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1; alu_valid = 1'b1; mem_valid = 1'b0; rf_hold = 1'b0;
        alu_data = 32'hFFFF_FFFF; alu_waddr = 5'd9;
        repeat (cycles) @(posedge clk);
        #1;
        modelReset();
        reset = 1'b0; alu_valid = 1'b0;
        #1;
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("rst_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("rst_mem_to_reg", 32'(mem_to_reg), 32'd0);
        checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("rst_rf_wdata", rf_wdata, 32'd0);
    endtask

    task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic [4:0] aa,
                                 input logic mv, input logic [31:0] md, input logic [4:0] ma,
                                 input logic hold);
        int         g;
        logic       exp_ar, exp_mr;
        logic [4:0] gaddr;
        alu_valid = av; alu_data = ad; alu_waddr = aa;
        mem_valid = mv; mem_data = md; mem_waddr = ma;
        rf_hold = hold;
        #1;
        g = 0;
        if (!hold) begin
            if (a_full && m_full) begin
                if (a_addr == m_addr)      g = (m_seq < a_seq) ? 2 : 1;
                else if (losses >= MAX_WAIT) g = 1;
                else                       g = 2;
            end else if (a_full) g = 1;
            else if (m_full)     g = 2;
        end
        exp_ar = !a_full || (g == 1);
        exp_mr = !m_full || (g == 2);
        obs_ar = alu_ready; obs_mr = mem_ready;
        checkOutput("alu_ready", 32'(alu_ready), 32'(exp_ar));
        checkOutput("mem_ready", 32'(mem_ready), 32'(exp_mr));

        exp_we = 0;
        if (g != 0) begin
            gaddr = (g == 2) ? m_addr : a_addr;
            if (gaddr != 5'd0) begin
                exp_we = 1; exp_waddr = gaddr;
                exp_wdata = (g == 2) ? m_data : a_data;
                exp_m2r = (g == 2); m2r_known = 1;
            end else begin
                m2r_known = 0;
            end
        end
        if (a_full && m_full && !hold && exp_conf < 65535) exp_conf++;
        if (hold && (a_full || m_full) && exp_hold < 65535) exp_hold++;
        if (!a_full || g == 1) losses = 0;
        else if (g == 2 && losses < MAX_WAIT) losses++;
        if (g == 1) a_full = 0;
        if (g == 2) m_full = 0;
        if (mv && exp_mr) begin m_full = 1; m_data = md; m_addr = ma; m_seq = seq_ctr++; end
        if (av && exp_ar) begin a_full = 1; a_data = ad; a_addr = aa; a_seq = seq_ctr++; end

        @(posedge clk);
        #1;
        checkOutput("rf_we", 32'(rf_we), 32'(exp_we));
        checkOutput("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
        checkOutput("rf_wdata", rf_wdata, exp_wdata);
        if (m2r_known) checkOutput("mem_to_reg", 32'(mem_to_reg), 32'(exp_m2r));
`ifdef WB_PERF_EN
        checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(exp_conf));
        checkOutput("hold_cnt", 32'(hold_cnt), 32'(exp_hold));
`endif
        if (rf_we) begin
            regfile[rf_waddr] = rf_wdata;
            grant_log.push_back(mem_to_reg);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regfile[r] = '0;
        reset = 1'b1; alu_valid = 0; mem_valid = 0; rf_hold = 0;
        alu_data = '0; mem_data = '0; alu_waddr = '0; mem_waddr = '0;
        modelReset();
        doReset(2);

        // Lone ALU write
        applyStimulus(1'b1, 32'h1234, 5'd5, 1'b0, 32'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
        checkOutput("lone_we", 32'(rf_we), 32'd1);
        checkOutput("lone_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("lone_wdata", rf_wdata, 32'h1234);
        checkOutput("lone_m2r", 32'(mem_to_reg), 32'd0);
        idle(2);

        // Continuous contention with distinct destinations
        grant_log.delete();
        for (int i = 0; i < 11; i++)
            applyStimulus(1'b1, 32'hA000 + 32'(i), 5'd1, 1'b1, 32'hB000 + 32'(i), 5'd2, 1'b0);
        checkOutput("fair_len", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < grant_log.size())
                checkOutput($sformatf("fair_%0d", i), 32'(grant_log[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
        idle(8);

        // Same destination captured on one edge
        grant_log.delete();
        applyStimulus(1'b1, 32'd1, 5'd7, 1'b1, 32'd2, 5'd7, 1'b0);
        idle(3);
        checkOutput("same_len", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            checkOutput("same_first_mem", 32'(grant_log[0]), 32'd1);
            checkOutput("same_second_alu", 32'(grant_log[1]), 32'd0);
        end
        checkOutput("same_reg7", regfile[7], 32'd1);

        // Load to register zero
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
        checkOutput("zero_mem_ready", 32'(obs_mr), 32'd1);
        checkOutput("zero_rf_we", 32'(rf_we), 32'd0);
        idle(1);

        // Held write port with both slots full
        doReset(1);
        applyStimulus(1'b1, 32'hA, 5'd3, 1'b1, 32'hB, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hC, 5'd6, 1'b1, 32'hD, 5'd8, 1'b1);
            checkOutput($sformatf("hold_alu_ready_%0d", i), 32'(obs_ar), 32'd0);
            checkOutput($sformatf("hold_mem_ready_%0d", i), 32'(obs_mr), 32'd0);
            checkOutput($sformatf("hold_rf_we_%0d", i), 32'(rf_we), 32'd0);
        end
`ifdef WB_PERF_EN
        checkOutput("hold_cnt_3", 32'(hold_cnt), 32'd3);
`endif
        grant_log.delete();
        idle(3);
        checkOutput("hold_len", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            checkOutput("hold_first_mem", 32'(grant_log[0]), 32'd1);
            checkOutput("hold_second_alu", 32'(grant_log[1]), 32'd0);
        end

        // Randomized traffic, with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset(1);
            applyStimulus(1'($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(1, 4)),
                          1'($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(1, 4)),
                          1'($urandom_range(0, 4) == 0));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
